vec_mem_sequencer: RTL and testbench



---
 rtl/vec_mem_sequencer.sv | 115 +++++++++++
 tb/tb_vec_mem_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_mem_sequencer.sv
// Vector memory-access sequencer: expands one vector load/store request into
// LANES single-word memory accesses, highest lane first, feeding the load collector.
module vec_mem_sequencer #(
    parameter int DATA_W = 16,
    parameter int LANES  = 16,
    parameter int ADDR_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    is_store,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [4:0]              RD_in,
    input  logic [LANES*DATA_W-1:0] store_data,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_we,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic                    enable_read,
    output logic [4:0]              RD_out
);

    localparam int IDX_W = $clog2(LANES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(LANES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, REARM, STORE, DONE} state_t;

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        idx_dec;
    logic [ADDR_W-1:0]       base_q;
    logic [LANES*DATA_W-1:0] data_q;
    logic                    accept;

    assign accept  = (state == IDLE) && start;
    assign idx_dec = idx - 1'b1;

    // NOTE: the request payload is not reset; it is only read after an accept
    // has loaded it, so a reset term would just add fanout on a wide register.
    always_ff @(posedge clk) begin
        if (accept) begin
            base_q <= base_addr;
            data_q <= store_data;
        end
    end

    // NOTE: all state and outputs use non-blocking assignments so every output
    // is a flop and reads of state within this block see the pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            idx         <= LAST;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
            enable_read <= 1'b0;
            RD_out      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        RD_out   <= RD_in;
                        idx      <= LAST;
                        mem_addr <= base_addr + ADDR_W'(LAST);
                        if (is_store) begin
                            state     <= STORE;
                            mem_we    <= 1'b1;
                            mem_wdata <= store_data[LAST*DATA_W +: DATA_W];
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    // Read data trails the address by one cycle.
                    enable_read <= 1'b1;
                    if (idx == '0) begin
                        state <= DRAIN;
                    end else begin
                        idx      <= idx_dec;
                        mem_addr <= base_q + ADDR_W'(idx_dec);
                    end
                end
                DRAIN: state <= REARM;
                REARM: begin
                    // The extra strobe during REARM wraps the collector's word counter.
                    state       <= DONE;
                    enable_read <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                end
                STORE: begin
                    if (idx == '0) begin
                        state  <= DONE;
                        mem_we <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        idx       <= idx_dec;
                        mem_addr  <= base_q + ADDR_W'(idx_dec);
                        mem_wdata <= data_q[idx_dec*DATA_W +: DATA_W];
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Self-checking bench for vec_mem_sequencer: directed and random requests checked
// cycle by cycle against the request timeline, a memory model and a collector model.
module tb_vec_mem_sequencer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         is_store = 1'b0;
    logic [15:0]  base_addr = '0;
    logic [4:0]   RD_in = '0;
    logic [255:0] store_data = '0;
    logic         busy, done, mem_we, enable_read;
    logic [15:0]  mem_addr, mem_wdata;
    logic [4:0]   RD_out;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    vec_mem_sequencer #(.DATA_W(16), .LANES(16), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store),
        .base_addr(base_addr), .RD_in(RD_in), .store_data(store_data),
        .busy(busy), .done(done), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .enable_read(enable_read), .RD_out(RD_out)
    );

    // Contents of the modelled data memory.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] p;
        p = a * 16'h9E37;
        return p ^ 16'h5A5A;
    endfunction

    function automatic logic [255:0] rand_vec();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Synchronous-read memory plus a collector that fills lanes 15..0 in strobe order.
    logic [15:0] rdata = '0;
    int          col_cnt = 0;
    logic [15:0] col_lane [16];
    int          wr_cnt = 0;
    logic [15:0] wr_addr [16];
    logic [15:0] wr_data [16];

    always @(posedge clk) begin
        if (enable_read) begin
            if (col_cnt < 16) col_lane[15-col_cnt] = rdata;
            col_cnt++;
        end else if (!busy) begin
            col_cnt = 0;
        end
        if (mem_we) begin
            if (wr_cnt < 16) begin
                wr_addr[wr_cnt] = mem_addr;
                wr_data[wr_cnt] = mem_wdata;
            end
            wr_cnt++;
        end else if (!busy) begin
            wr_cnt = 0;
        end
        rdata <= mem_word(mem_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic st, input logic [15:0] b, input logic [4:0] rd,
                           input logic [255:0] d);
        is_store   = st;
        base_addr  = b;
        RD_in      = rd;
        store_data = d;
        start      = 1'b1;
    endtask

    // Called with the request already driven; returns at the falling edge of the done cycle.
    task automatic run_req(input logic st, input logic [15:0] b, input logic [4:0] rd,
                           input logic [255:0] d, input bit hold);
        int          len;
        logic [15:0] ea;
        len = st ? 17 : 19;
        @(posedge clk);
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (k == 1 && !hold) begin
                start      = 1'b0;
                base_addr  = 16'($urandom);
                RD_in      = 5'($urandom);
                store_data = rand_vec();
                is_store   = ~st;
            end
            ea = (k <= 16) ? b + 16'(16 - k) : b;
            check($sformatf("busy c%0d", k), busy, k < len);
            check($sformatf("done c%0d", k), done, k == len);
            check($sformatf("mem_we c%0d", k), mem_we, st && k <= 16);
            check($sformatf("enable_read c%0d", k), enable_read, !st && k >= 2 && k <= 18);
            check($sformatf("RD_out c%0d", k), RD_out, rd);
            check($sformatf("mem_addr c%0d", k), mem_addr, ea);
            if (st && k <= 16)
                check($sformatf("mem_wdata c%0d", k), mem_wdata, d[(16-k)*16 +: 16]);
        end
        if (st) begin
            check("store write count", wr_cnt, 16);
            for (int j = 0; j < 16; j++) begin
                check($sformatf("store addr #%0d", j), wr_addr[j], b + 16'(15 - j));
                check($sformatf("store data #%0d", j), wr_data[j], d[(15-j)*16 +: 16]);
            end
        end else begin
            check("load strobe count", col_cnt, 17);
            for (int i = 0; i < 16; i++)
                check($sformatf("collector lane %0d", i), col_lane[i], mem_word(b + 16'(i)));
        end
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle busy", busy, 0);
            check("idle mem_we", mem_we, 0);
            check("idle enable_read", enable_read, 0);
        end
    endtask

    initial begin
        logic [255:0] d;
        logic [15:0]  b;
        logic [4:0]   rd;
        logic         st;

        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset mem_we", mem_we, 0);
        check("reset mem_wdata", mem_wdata, 0);
        check("reset enable_read", enable_read, 0);
        check("reset RD_out", RD_out, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle_gap(2);

        // Load at 0x0100 into v5.
        d = rand_vec();
        set_req(1'b0, 16'h0100, 5'd5, d);
        run_req(1'b0, 16'h0100, 5'd5, d, 1'b0);
        idle_gap(1);
        check("RD_out held after load", RD_out, 5);
        check("mem_addr held in idle", mem_addr, 16'h0100);

        // Store of 0xA000+i at 0x0200.
        for (int i = 0; i < 16; i++) d[i*16 +: 16] = 16'hA000 + 16'(i);
        set_req(1'b1, 16'h0200, 5'd1, d);
        run_req(1'b1, 16'h0200, 5'd1, d, 1'b0);
        idle_gap(1);
        check("mem_wdata held in idle", mem_wdata, 16'hA000);

        // Address wrap.
        d = rand_vec();
        set_req(1'b0, 16'hFFF8, 5'd12, d);
        run_req(1'b0, 16'hFFF8, 5'd12, d, 1'b0);

        // start held through a load and the DONE cycle, then accepted from IDLE.
        idle_gap(1);
        d = rand_vec();
        set_req(1'b0, 16'h0300, 5'd7, d);
        run_req(1'b0, 16'h0300, 5'd7, d, 1'b1);
        @(negedge clk);
        check("no accept in DONE: busy", busy, 0);
        check("no accept in DONE: done", done, 0);
        check("no accept in DONE: RD_out", RD_out, 7);
        d = rand_vec();
        set_req(1'b0, 16'h0400, 5'd11, d);
        run_req(1'b0, 16'h0400, 5'd11, d, 1'b0);

        // Reset in cycle 8 of a store.
        idle_gap(1);
        d = rand_vec();
        set_req(1'b1, 16'h0500, 5'd2, d);
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre-reset mem_we", mem_we, 1);
        rst = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort mem_we", mem_we, 0);
        check("abort done", done, 0);
        check("abort enable_read", enable_read, 0);
        check("abort mem_addr", mem_addr, 0);
        check("abort RD_out", RD_out, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("in reset done", done, 0);
        end
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("after reset done", done, 0);
            check("after reset busy", busy, 0);
        end
        d = rand_vec();
        set_req(1'b0, 16'h0600, 5'd20, d);
        run_req(1'b0, 16'h0600, 5'd20, d, 1'b0);

        // Back-to-back loads, RD 3 then RD 9.
        idle_gap(1);
        d = rand_vec();
        set_req(1'b0, 16'h0700, 5'd3, d);
        run_req(1'b0, 16'h0700, 5'd3, d, 1'b0);
        @(negedge clk);
        check("RD_out before 2nd accept", RD_out, 3);
        d = rand_vec();
        set_req(1'b0, 16'h0710, 5'd9, d);
        run_req(1'b0, 16'h0710, 5'd9, d, 1'b0);

        // Random requests.
        for (int n = 0; n < 12; n++) begin
            idle_gap(1 + int'($urandom_range(0, 3)));
            st = 1'($urandom);
            b  = 16'($urandom);
            rd = 5'($urandom);
            d  = rand_vec();
            set_req(st, b, rd, d);
            run_req(st, b, rd, d, 1'b0);
        end

        idle_gap(2);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
